pc_pipe_ctrl: RTL

//  Sequencer for the fetch counter and the two downstream pipeline registers.

---
 rtl/pc_pipe_ctrl_pkg.sv | 14 +
 rtl/pc_pipe_ctrl_stage.sv | 28 ++
 rtl/pc_pipe_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/pc_pipe_ctrl_pkg.sv
// Shared types and defaults for the fetch-counter / pipeline sequencer.
package pc_pipe_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned RESET_PC_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_pipe_ctrl_stage.sv
// One pipeline stage register: address plus valid bit.
// clr drops the valid bit and keeps the address; it takes priority over we.
module pipe_stage_reg #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] d,
  input  logic              d_valid,
  output logic [ADDR_W-1:0] q,
  output logic              q_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (we) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/pc_pipe_ctrl.sv
// Program-counter sequencer with two trailing pipeline stages and a sticky halt.
// Requests are arbitrated as rst > halt > jump > stall > en.
module pc_pipe_ctrl
  import pc_pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall_req,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] s1_pc,
  output logic              s1_valid,
  output logic [ADDR_W-1:0] s2_pc,
  output logic              s2_valid,
  output logic              pc_we,
  output logic              stg_we,
  output logic [1:0]        state,
  output logic              halted
);

  state_t            state_q;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic              advance;
  logic              jump_ld;
  logic              drain;

  // Drain shifts the stages with a bubble entering stage 1, so work
  // already in flight retires while the counter stays frozen.
  always_comb begin
    advance   = 1'b0;
    jump_ld   = 1'b0;
    drain     = 1'b0;
    state_nxt = state_q;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (halt_req)  state_nxt = ST_HALT;
          else if (en)   state_nxt = ST_RUN;
        end
        ST_RUN, ST_STALL: begin
          if (halt_req) begin
            state_nxt = ST_HALT;
            drain     = s1_valid | s2_valid;
          end else if (jump_req) begin
            state_nxt = ST_RUN;
            jump_ld   = 1'b1;
          end else if (stall_req) begin
            state_nxt = ST_STALL;
          end else if (en) begin
            state_nxt = ST_RUN;
            advance   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_HALT: begin
          drain = s1_valid | s2_valid;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign pc_we  = advance | jump_ld;
  assign stg_we = advance | jump_ld | drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_nxt;
      if (jump_ld)      pc_q <= jump_addr;
      else if (advance) pc_q <= pc_q + ADDR_W'(1);
    end
  end

  pipe_stage_reg #(.ADDR_W(ADDR_W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .we      (stg_we),
    .clr     (jump_ld),
    .d       (pc_q),
    .d_valid (advance),
    .q       (s1_pc),
    .q_valid (s1_valid)
  );

  pipe_stage_reg #(.ADDR_W(ADDR_W)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .we      (stg_we),
    .clr     (jump_ld),
    .d       (s1_pc),
    .d_valid (s1_valid),
    .q       (s2_pc),
    .q_valid (s2_valid)
  );

  assign pc     = pc_q;
  assign state  = state_q;
  assign halted = (state_q == ST_HALT) && !s1_valid && !s2_valid;

endmodule
